// File: rtl/mem_arb_pkg.sv
// Shared encodings for the instruction/data memory port arbiter.
// Grant and response-state enums are used by the top and the winner picker.
package mem_arb_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_I    = 2'd1,
        GNT_D    = 2'd2
    } gnt_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RESP_I = 2'd1,
        RESP_D = 2'd2
    } resp_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the fetch and data requesters.
// Fixed mode favours data unless fetch has waited MAX_WAIT cycles; RR alternates.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int ARB_MODE = ARB_FIXED,
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 3
) (
    input  logic             i_req,
    input  logic             d_req,
    input  logic [CNT_W-1:0] starve_cnt,
    input  gnt_e             last_grant,
    output gnt_e             winner
);

    always_comb begin
        winner = GNT_NONE;
        if (i_req && d_req) begin
            if (ARB_MODE == ARB_RR) begin
                winner = (last_grant == GNT_D) ? GNT_I : GNT_D;
            end else begin
                winner = (starve_cnt == CNT_W'(MAX_WAIT)) ? GNT_I : GNT_D;
            end
        end else if (i_req) begin
            winner = GNT_I;
        end else if (d_req) begin
            winner = GNT_D;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one word-addressed memory between fetch (read-only) and load/store ports.
// Grants and memory strobes are combinational; read data returns one cycle later.
//
//   state  | meaning
//   IDLE   | no response pending
//   RESP_I | fetch response valid this cycle
//   RESP_D | data response valid this cycle
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int MEM_SIZE = 256,
    parameter int ARB_MODE = ARB_FIXED,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [ADDR_W-1:0] i_rdata,
    output logic              i_err,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [ADDR_W-1:0] d_wdata,
    input  logic              d_we,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [ADDR_W-1:0] d_rdata,
    output logic              d_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ADDR_W-1:0] mem_din,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [ADDR_W-1:0] mem_dout
);

    localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    gnt_e              pick_gnt;
    gnt_e              gnt;
    gnt_e              last_grant;
    resp_e             state;
    resp_e             state_next;
    logic [CNT_W-1:0]  starve_cnt;
    logic [ADDR_W-1:0] sel_addr;
    logic [ADDR_W-1:0] resp_data;
    logic              is_store;
    logic              in_range;

    mem_arb_pick #(
        .ARB_MODE (ARB_MODE),
        .MAX_WAIT (MAX_WAIT),
        .CNT_W    (CNT_W)
    ) u_pick (
        .i_req      (i_req),
        .d_req      (d_req),
        .starve_cnt (starve_cnt),
        .last_grant (last_grant),
        .winner     (pick_gnt)
    );

    // No grant while reset is held, so the memory strobes drop immediately.
    assign gnt   = rst_n ? pick_gnt : GNT_NONE;
    assign i_gnt = (gnt == GNT_I);
    assign d_gnt = (gnt == GNT_D);

    always_comb begin
        sel_addr = '0;
        is_store = 1'b0;
        case (gnt)
            GNT_I: sel_addr = i_addr;
            GNT_D: begin
                sel_addr = d_addr;
                is_store = d_we;
            end
            default: ;
        endcase
    end

    assign in_range  = ({1'b0, sel_addr} < (ADDR_W + 1)'(MEM_SIZE));
    assign mem_addr  = sel_addr;
    assign mem_din   = d_gnt ? d_wdata : '0;
    assign mem_we    = d_gnt && d_we && in_range;
    assign mem_re    = (gnt != GNT_NONE) && !is_store && in_range;
    assign resp_data = (in_range && !is_store) ? mem_dout : '0;

    always_comb begin
        state_next = IDLE;
        case (gnt)
            GNT_I:   state_next = RESP_I;
            GNT_D:   state_next = RESP_D;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    assign i_rvalid = (state == RESP_I);
    assign d_rvalid = (state == RESP_D);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_rdata <= '0;
            i_err   <= 1'b0;
            d_rdata <= '0;
            d_err   <= 1'b0;
        end else begin
            if (i_gnt) begin
                i_rdata <= resp_data;
                i_err   <= !in_range;
            end
            if (d_gnt) begin
                d_rdata <= resp_data;
                d_err   <= !in_range;
            end
        end
    end

    // Counts cycles a fetch has been refused; saturates so the guard stays armed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            last_grant <= GNT_D;
        end else begin
            if (!i_req || i_gnt) begin
                starve_cnt <= '0;
            end else if (starve_cnt != CNT_W'(MAX_WAIT)) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
            if (gnt != GNT_NONE) begin
                last_grant <= gnt;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fixed-priority instance on a small memory model,
// plus a round-robin instance for grant alternation.
module tb_mem_port_arbiter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         preload;

    logic         i_req, d_req, d_we;
    logic [W-1:0] i_addr, d_addr, d_wdata;
    logic         i_gnt, i_rvalid, i_err, d_gnt, d_rvalid, d_err;
    logic [W-1:0] i_rdata, d_rdata;
    logic [W-1:0] mem_addr, mem_din, mem_dout;
    logic         mem_we, mem_re;

    logic         rr_i_req, rr_d_req;
    logic         rr_i_gnt, rr_i_rvalid, rr_i_err, rr_d_gnt, rr_d_rvalid, rr_d_err;
    logic [W-1:0] rr_i_rdata, rr_d_rdata, rr_mem_addr, rr_mem_din;
    logic         rr_mem_we, rr_mem_re;
    logic [W-1:0] rr_addr = '0;
    logic [W-1:0] rr_mem_dout = 32'h0000_5555;

    logic [W-1:0] mem [0:255];

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(W), .MEM_SIZE(256), .ARB_MODE(0), .MAX_WAIT(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
        .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_we(d_we),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_re(mem_re),
        .mem_dout(mem_dout)
    );

    mem_port_arbiter #(.ADDR_W(W), .MEM_SIZE(256), .ARB_MODE(1), .MAX_WAIT(4)) u_dut_rr (
        .clk(clk), .rst_n(rst_n),
        .i_req(rr_i_req), .i_addr(rr_addr), .i_gnt(rr_i_gnt), .i_rvalid(rr_i_rvalid),
        .i_rdata(rr_i_rdata), .i_err(rr_i_err),
        .d_req(rr_d_req), .d_addr(rr_addr), .d_wdata(rr_addr), .d_we(1'b0),
        .d_gnt(rr_d_gnt), .d_rvalid(rr_d_rvalid), .d_rdata(rr_d_rdata), .d_err(rr_d_err),
        .mem_addr(rr_mem_addr), .mem_din(rr_mem_din), .mem_we(rr_mem_we), .mem_re(rr_mem_re),
        .mem_dout(rr_mem_dout)
    );

    // Memory model aliases on the low address bits, so any leaked out-of-range write shows up.
    always @(posedge clk) begin
        if (preload) begin
            mem[0] <= 32'h1111_0000;
            mem[3] <= 32'h0030_0083;
            mem[9] <= 32'h0000_0000;
        end else if (mem_we) begin
            mem[mem_addr[7:0]] <= mem_din;
        end
    end
    assign mem_dout = mem[mem_addr[7:0]];

    task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic idle_inputs();
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_addr = '0; d_wdata = '0; d_we = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rr_i_req = 1'b0; rr_d_req = 1'b0;
        rst_n = 1'b0; preload = 1'b1;
        d_req = 1'b1; i_req = 1'b1; i_addr = 32'd3;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_re", {31'b0, mem_re}, 0);
        chk("rst_mem_we", {31'b0, mem_we}, 0);
        chk("rst_gnt", {30'b0, i_gnt, d_gnt}, 0);
        chk("rst_rvalid", {30'b0, i_rvalid, d_rvalid}, 0);
        chk("rst_rdata", i_rdata | d_rdata, 0);
        chk("rst_err", {30'b0, i_err, d_err}, 0);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1; preload = 1'b0;

        // fetch only
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'd3;
        #1;
        chk("f_gnt", {30'b0, i_gnt, d_gnt}, 32'd2);
        chk("f_mem_re", {31'b0, mem_re}, 1);
        chk("f_mem_addr", mem_addr, 32'd3);
        @(posedge clk); #1;
        chk("f_rvalid", {31'b0, i_rvalid}, 1);
        chk("f_rdata", i_rdata, 32'h0030_0083);
        chk("f_err", {31'b0, i_err}, 0);
        @(negedge clk);
        idle_inputs();
        @(posedge clk); #1;
        chk("f_rvalid_drop", {31'b0, i_rvalid}, 0);
        chk("f_rdata_hold", i_rdata, 32'h0030_0083);

        // store then back-to-back load
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'd9; d_wdata = 32'h0000_002A;
        #1;
        chk("st_gnt", {30'b0, i_gnt, d_gnt}, 32'd1);
        chk("st_mem_we", {31'b0, mem_we}, 1);
        chk("st_mem_re", {31'b0, mem_re}, 0);
        chk("st_mem_din", mem_din, 32'h0000_002A);
        @(posedge clk); #1;
        chk("st_rvalid", {31'b0, d_rvalid}, 1);
        chk("st_rdata", d_rdata, 0);
        @(negedge clk);
        d_we = 1'b0;
        #1;
        chk("ld_gnt", {31'b0, d_gnt}, 1);
        chk("ld_mem_re", {31'b0, mem_re}, 1);
        @(posedge clk); #1;
        chk("ld_rvalid", {31'b0, d_rvalid}, 1);
        chk("ld_rdata", d_rdata, 32'h0000_002A);
        @(negedge clk);
        idle_inputs();

        // starvation guard: d wins cycles 0-3, i wins cycle 4, d resumes
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'd3;
        d_req = 1'b1; d_addr = 32'd0; d_we = 1'b0;
        for (int c = 0; c < 7; c++) begin
            #1;
            chk($sformatf("sv_gnt_c%0d", c), {30'b0, i_gnt, d_gnt},
                (c == 4) ? 32'd2 : 32'd1);
            @(posedge clk); #1;
            if (c == 4) begin
                chk("sv_i_rvalid", {31'b0, i_rvalid}, 1);
                chk("sv_i_rdata", i_rdata, 32'h0030_0083);
            end
            @(negedge clk);
        end
        idle_inputs();

        // round-robin instance: fetch first, then alternate
        @(negedge clk);
        rr_i_req = 1'b1; rr_d_req = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("rr_gnt_c%0d", c), {30'b0, rr_i_gnt, rr_d_gnt},
                (c % 2 == 0) ? 32'd2 : 32'd1);
            @(negedge clk);
        end
        rr_i_req = 1'b0; rr_d_req = 1'b0;

        // out-of-range store is blocked and reported
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'd256; d_wdata = 32'hFFFF_FFFF;
        #1;
        chk("oor_gnt", {31'b0, d_gnt}, 1);
        chk("oor_mem_we", {31'b0, mem_we}, 0);
        chk("oor_mem_re", {31'b0, mem_re}, 0);
        @(posedge clk); #1;
        chk("oor_rvalid", {31'b0, d_rvalid}, 1);
        chk("oor_err", {31'b0, d_err}, 1);
        chk("oor_rdata", d_rdata, 0);
        @(negedge clk);
        d_we = 1'b0; d_addr = 32'd0;
        @(posedge clk); #1;
        chk("oor_ld0_err", {31'b0, d_err}, 0);
        chk("oor_ld0_rdata", d_rdata, 32'h1111_0000);
        @(negedge clk);
        idle_inputs();

        // reset in the middle of a granted fetch
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'd3;
        #1;
        chk("rm_gnt", {31'b0, i_gnt}, 1);
        chk("rm_mem_re", {31'b0, mem_re}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rm_mem_re_low", {31'b0, mem_re}, 0);
        chk("rm_gnt_low", {31'b0, i_gnt}, 0);
        @(posedge clk); #1;
        chk("rm_rvalid", {31'b0, i_rvalid}, 0);
        chk("rm_rdata", i_rdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rm_regnt", {31'b0, i_gnt}, 1);
        @(posedge clk); #1;
        chk("rm_rvalid2", {31'b0, i_rvalid}, 1);
        chk("rm_rdata2", i_rdata, 32'h0030_0083);
        @(negedge clk);
        idle_inputs();
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single word-addressed instruction/data memory between the fetch unit (read-only port "i") and the load/store unit (read/write port "d"). It picks one requester per cycle, drives the memory's addr/Din/we/re combinationally, and registers the memory's combinational read data into a one-cycle-later response. It also blocks out-of-range accesses and guarantees fetch forward progress under continuous data traffic.

Parameters:
ADDR_W, 32, address and data width of all ports
MEM_SIZE, 256, number of memory words; legal addresses are 0..MEM_SIZE-1
ARB_MODE, 0, 0 = data priority with starvation guard; 1 = round-robin
MAX_WAIT, 4, cycles a pending fetch may lose before it is forced to win (ARB_MODE 0)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
i_req  in  1  fetch request; held with i_addr until i_gnt
i_addr  in  ADDR_W  fetch word address
i_gnt  out  1  combinational grant for fetch, this cycle
i_rvalid  out  1  fetch response valid, exactly 1 cycle after i_gnt
i_rdata  out  ADDR_W  fetch read data
i_err  out  1  with i_rvalid: address was out of range
d_req  in  1  data request; held with d_addr/d_wdata/d_we until d_gnt
d_addr  in  ADDR_W  data word address
d_wdata  in  ADDR_W  store data
d_we  in  1  1 = store, 0 = load
d_gnt  out  1  combinational grant for data
d_rvalid  out  1  data response/ack, 1 cycle after d_gnt (loads and stores)
d_rdata  out  ADDR_W  load data (0 for stores)
d_err  out  1  with d_rvalid: address out of range
mem_addr  out  ADDR_W  to memory addr
mem_din  out  ADDR_W  to memory Din
mem_we  out  1  to memory we
mem_re  out  1  to memory re
mem_dout  in  ADDR_W  from memory out (combinational read)

Behaviour:
- Reset (rst_n low, async): i_rvalid=d_rvalid=0, i_rdata=d_rdata=0, i_err=d_err=0, starvation counter=0, last_grant=D (so round-robin favours fetch first). mem_we and mem_re are forced to 0 while rst_n is low, even with requests pending. Memory contents are not touched.
- At most one grant per cycle. i_gnt and d_gnt are never both 1.
- A grant is given in the same cycle as the request, if the request wins arbitration.
- Requester signals must stay stable until their grant. A new request may be presented in the cycle right after a grant, so back-to-back grants at 1 access per cycle are allowed.
- Granted cycle: mem_addr=granted addr, mem_re=1 for any access that is not a store, mem_we=d_we (data port only), mem_din=d_wdata. The memory performs the write at that rising edge.
- Ungranted cycle: mem_we=0, mem_re=0, mem_addr=0, mem_din=0.
- Response: at the rising edge that ends the grant cycle, the granted port's rvalid is set for exactly 1 cycle.
  - Loads and fetches: rdata captures mem_dout.
  - Stores: rdata is 0.
  - rdata holds its value when rvalid is 0.
- Out of range (addr >= MEM_SIZE): the grant is still given, but mem_we=0 and mem_re=0. The response has err=1 and rdata=0.
- ARB_MODE 0:
  - Only one request pending: it wins.
  - Both pending: d wins, unless starve_cnt==MAX_WAIT, in which case i wins.
  - starve_cnt increments on each cycle with i_req=1 and i_gnt=0, saturating at MAX_WAIT. It clears on i_gnt or when i_req=0.
- ARB_MODE 1: both pending -> the port not in last_grant wins. last_grant updates on every grant.
- Reset asserted mid-access: the pending response is discarded (rvalid=0) and the requester must re-request. Releasing reset starts in the idle condition.
- Idle/status state machine: IDLE (no response pending) -> RESP_I or RESP_D on grant. RESP_x -> RESP_x/RESP_other on a back-to-back grant, or -> IDLE. The state drives the rvalid outputs.

Decomposition:
- Package mem_arb_pkg:
  - ARB_FIXED=0, ARB_RR=1
  - grant encoding GNT_NONE, GNT_I, GNT_D
  - response state encoding IDLE, RESP_I, RESP_D
- Sub-module mem_arb_pick: combinational winner selection from i_req, d_req, starve_cnt, last_grant, ARB_MODE. The top level holds the counter, registers and memory muxing.

Test Plan:
- Fetch only: memory word 3=0x00300083; i_req=1, i_addr=3 -> i_gnt=1 and mem_re=1, mem_addr=3 the same cycle; next cycle i_rvalid=1, i_rdata=0x00300083, i_err=0.
- Store then load: d store addr 9 data 0x0000002A, then load addr 9 back-to-back -> two d_gnt cycles; d_rvalid=1 on both following cycles; second d_rdata=0x0000002A.
- Starvation (MODE 0, MAX_WAIT=4): d_req continuous, i_req continuous -> d_gnt on cycles 0-3; i_gnt on cycle 4; d_gnt resumes on cycle 5.
- Round-robin (MODE 1): both requesting continuously after reset -> grants alternate I,D,I,D.
- Out of range: d store addr 256 data 0xFFFFFFFF -> d_gnt=1 with mem_we=0; next cycle d_err=1, d_rdata=0; a later load of addr 0 returns its original value.
- Reset mid-access: grant a fetch, drop rst_n before the next edge -> i_rvalid stays 0 and mem_re drops immediately. After release, the same request completes normally.
